// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Function : Shared state encodings, register selects and status bit
//             positions for the CPLD UART bus controller.
//  Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE       = 3'd0;
    localparam state_t c_ST_TX_WAIT    = 3'd1;
    localparam state_t c_ST_WR_SETUP   = 3'd2;
    localparam state_t c_ST_WR_PULSE   = 3'd3;
    localparam state_t c_ST_WR_HOLD    = 3'd4;
    localparam state_t c_ST_RD_PULSE   = 3'd5;
    localparam state_t c_ST_RD_RECOVER = 3'd6;
    localparam state_t c_ST_DONE       = 3'd7;

    localparam logic SEL_DATA   = 1'b0;
    localparam logic SEL_STATUS = 1'b1;

    localparam int STAT_TX_BIT = 0;
    localparam int STAT_RX_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync2
//  Function : Single-bit two-flop synchronizer for asynchronous CPLD flags.
//  Revision : 1.0
// ============================================================================
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/cpld_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpld_uart_ctrl
//  Function : Turns MMU word requests into timed uart_rdn/uart_wrn strobes on
//             the shared BaseRAM low byte; answers with a one-cycle response.
//  Revision : 1.0
// ============================================================================
module cpld_uart_ctrl
    import uart_pkg::*;
#(
    parameter int PULSE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_sel,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        busy,
    input  logic [7:0]  bus_data_i,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre
);

    localparam int                 c_CNT_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [2:0]         w_async;
    logic [2:0]         w_synced;
    logic               w_rx_ready;
    logic               w_tx_ready;
    logic [31:0]        w_status;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic               r_resp_valid;
    logic [31:0]        r_rdata;
    logic               r_busy;
    logic [7:0]         r_wdata;
    logic               r_oe;
    logic               r_rdn;
    logic               r_wrn;

    assign w_async = {uart_tsre, uart_tbre, uart_dataready};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        uart_sync2 u_sync (
            .clk (clk),
            .rst (rst),
            .i_d (w_async[i]),
            .o_q (w_synced[i])
        );
    end

    assign w_rx_ready = w_synced[0];
    assign w_tx_ready = w_synced[1] & w_synced[2];

    always_comb begin
        w_status              = '0;
        w_status[STAT_TX_BIT] = w_tx_ready;
        w_status[STAT_RX_BIT] = w_rx_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    if (req_sel == SEL_STATUS) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (req_we) begin
                        w_state_nxt = w_tx_ready ? c_ST_WR_SETUP : c_ST_TX_WAIT;
                    end else begin
                        w_state_nxt = c_ST_RD_PULSE;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
            end
            c_ST_TX_WAIT: begin
                if (w_tx_ready) begin
                    w_state_nxt = c_ST_WR_SETUP;
                end
            end
            c_ST_WR_SETUP: begin
                w_state_nxt = c_ST_WR_PULSE;
                w_cnt_nxt   = c_CNT_LOAD;
            end
            c_ST_WR_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_WR_HOLD:    w_state_nxt = c_ST_DONE;
            c_ST_RD_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_RD_RECOVER;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            c_ST_RD_RECOVER: w_state_nxt = c_ST_DONE;
            c_ST_DONE:       w_state_nxt = c_ST_IDLE;
            default:         w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Strobes and enables are decoded from the next state so they change on
    // the same edge as the state and come straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_wdata      <= '0;
            r_oe         <= 1'b0;
            r_rdn        <= 1'b1;
            r_wrn        <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= (w_state_nxt == c_ST_DONE);
            r_busy       <= (w_state_nxt != c_ST_IDLE);
            r_rdn        <= (w_state_nxt != c_ST_RD_PULSE);
            r_wrn        <= (w_state_nxt != c_ST_WR_PULSE);
            r_oe         <= (w_state_nxt == c_ST_WR_SETUP) ||
                            (w_state_nxt == c_ST_WR_PULSE) ||
                            (w_state_nxt == c_ST_WR_HOLD);
            if (r_state == c_ST_IDLE && req_valid) begin
                if (req_sel == SEL_STATUS && !req_we) begin
                    r_rdata <= w_status;
                end
                if (req_sel == SEL_DATA && req_we) begin
                    r_wdata <= req_wdata;
                end
            end
            // Capture on the edge that ends the final low cycle of uart_rdn.
            if (r_state == c_ST_RD_PULSE && r_cnt == '0) begin
                r_rdata <= {24'b0, bus_data_i};
            end
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_rdata;
    assign busy        = r_busy;
    assign bus_data_o  = r_wdata;
    assign bus_data_oe = r_oe;
    assign uart_rdn    = r_rdn;
    assign uart_wrn    = r_wrn;

endmodule
`default_nettype wire

// File: tb/tb_cpld_uart_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cpld_uart_ctrl
//  Function : Self-checking bench; per-request timeline model plus directed
//             and randomized traffic.
//  Revision : 1.0
// ============================================================================
module tb_cpld_uart_ctrl;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_sel = 1'b0;
    logic [7:0]  req_wdata = 8'h00;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic [7:0]  bus_data_i = 8'h00;
    logic [7:0]  bus_data_o;
    logic        bus_data_oe;
    logic        uart_rdn;
    logic        uart_wrn;
    logic        uart_dataready = 1'b0;
    logic        uart_tbre = 1'b0;
    logic        uart_tsre = 1'b0;

    always #5 clk = ~clk;

    cpld_uart_ctrl #(.PULSE_CYCLES(P)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_sel        (req_sel),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .busy           (busy),
        .bus_data_i     (bus_data_i),
        .bus_data_o     (bus_data_o),
        .bus_data_oe    (bus_data_oe),
        .uart_rdn       (uart_rdn),
        .uart_wrn       (uart_wrn),
        .uart_dataready (uart_dataready),
        .uart_tbre      (uart_tbre),
        .uart_tsre      (uart_tsre)
    );

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one expected phase per clock cycle ----
    typedef struct packed {
        logic rdn;
        logic wrn;
        logic oe;
        logic rv;
        logic rd_last;
    } phase_t;

    phase_t      q[$];
    bit          waiting = 1'b0;
    bit          model_live = 1'b0;
    logic        m_tx1 = 1'b0, m_tx2 = 1'b0, m_rx1 = 1'b0, m_rx2 = 1'b0;
    logic [7:0]  e_data_o = 8'h00;
    logic [31:0] e_rdata = 32'h0;

    function automatic phase_t ph(input logic rdn, input logic wrn, input logic oe,
                                  input logic rv, input logic last);
        phase_t p;
        p.rdn = rdn; p.wrn = wrn; p.oe = oe; p.rv = rv; p.rd_last = last;
        return p;
    endfunction

    task automatic push_write();
        q.push_back(ph(1, 1, 1, 0, 0));
        for (int i = 0; i < P; i++) q.push_back(ph(1, 0, 1, 0, 0));
        q.push_back(ph(1, 1, 1, 0, 0));
        q.push_back(ph(1, 1, 0, 1, 0));
    endtask

    task automatic push_read();
        for (int i = 0; i < P; i++) q.push_back(ph(0, 1, 0, 0, (i == P - 1)));
        q.push_back(ph(1, 1, 0, 0, 0));
        q.push_back(ph(1, 1, 0, 1, 0));
    endtask

    initial begin : model
        phase_t cur;
        logic   tx_s, rx_s;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                waiting  = 1'b0;
                e_data_o = 8'h00;
                e_rdata  = 32'h0;
                m_tx1 = 1'b0; m_tx2 = 1'b0; m_rx1 = 1'b0; m_rx2 = 1'b0;
            end else begin
                // flags as seen two edges ago
                tx_s = m_tx2;
                rx_s = m_rx2;
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    if (cur.rd_last) e_rdata = {24'h0, bus_data_i};
                end else if (waiting) begin
                    if (tx_s) begin
                        waiting = 1'b0;
                        push_write();
                    end
                end else if (req_valid) begin
                    if (req_sel) begin
                        if (!req_we) e_rdata = {30'h0, rx_s, tx_s};
                        q.push_back(ph(1, 1, 0, 1, 0));
                    end else if (req_we) begin
                        e_data_o = req_wdata;
                        if (tx_s) push_write();
                        else      waiting = 1'b1;
                    end else begin
                        push_read();
                    end
                end
                m_tx2 = m_tx1;
                m_rx2 = m_rx1;
                m_tx1 = uart_tbre & uart_tsre;
                m_rx1 = uart_dataready;
            end
            model_live = 1'b1;
        end
    end

    initial begin : compare
        phase_t e;
        forever begin
            @(negedge clk);
            if (model_live) begin
                e = (q.size() != 0) ? q[0] : ph(1, 1, 0, 0, 0);
                chk("uart_rdn",    {31'h0, uart_rdn},    {31'h0, e.rdn});
                chk("uart_wrn",    {31'h0, uart_wrn},    {31'h0, e.wrn});
                chk("bus_data_oe", {31'h0, bus_data_oe}, {31'h0, e.oe});
                chk("resp_valid",  {31'h0, resp_valid},  {31'h0, e.rv});
                chk("busy",        {31'h0, busy},        {31'h0, (q.size() != 0 || waiting)});
                chk("bus_data_o",  {24'h0, bus_data_o},  {24'h0, e_data_o});
                chk("resp_rdata",  resp_rdata,           e_rdata);
                chk("strobe_excl", {31'h0, (!uart_rdn && !uart_wrn)}, 32'h0);
                chk("oe_vs_rdn",   {31'h0, (bus_data_oe && !uart_rdn)}, 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic cyc();
        @(negedge clk);
        if (rand_mode) begin
            if ($urandom_range(0, 3) == 0) uart_tbre = 1'($urandom);
            if ($urandom_range(0, 3) == 0) uart_tsre = 1'($urandom);
            if ($urandom_range(0, 3) == 0) uart_dataready = 1'($urandom);
            bus_data_i = 8'($urandom);
        end
    endtask

    // Raises a request one cycle after the previous response, then waits for it.
    task automatic do_req(input logic we, input logic sel, input logic [7:0] wd,
                          input bit toggle, output int lat, output int oe_n,
                          output int wrn_n, output int rdn_n,
                          output logic [31:0] rd, output logic data_ok);
        lat = -1; oe_n = 0; wrn_n = 0; rdn_n = 0; rd = '0; data_ok = 1'b1;
        cyc();
        req_valid = 1'b1; req_we = we; req_sel = sel; req_wdata = wd;
        for (int n = 1; n <= 300; n++) begin
            cyc();
            if (toggle) begin
                req_we  = 1'($urandom);
                req_sel = 1'($urandom);
            end
            if (bus_data_oe) oe_n++;
            if (!uart_wrn) begin
                wrn_n++;
                if (bus_data_o !== wd) data_ok = 1'b0;
            end
            if (!uart_rdn) rdn_n++;
            if (resp_valid) begin
                lat = n;
                rd  = resp_rdata;
                break;
            end
        end
        req_valid = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: no resp_valid within 300 cycles, required one");
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence --------------------------------------------
    initial begin : main
        int          lat, oe_n, wrn_n, rdn_n, n;
        logic [31:0] rd;
        logic        ok;

        repeat (3) @(negedge clk);
        chk("rst_rdn",   {31'h0, uart_rdn},    32'h1);
        chk("rst_wrn",   {31'h0, uart_wrn},    32'h1);
        chk("rst_oe",    {31'h0, bus_data_oe}, 32'h0);
        chk("rst_busy",  {31'h0, busy},        32'h0);
        chk("rst_rv",    {31'h0, resp_valid},  32'h0);
        chk("rst_rdata", resp_rdata,           32'h0);
        chk("rst_data_o",{24'h0, bus_data_o},  32'h0);
        rst = 1'b0;

        // Status reads
        uart_tbre = 1'b1; uart_tsre = 1'b1; uart_dataready = 1'b0;
        repeat (3) cyc();
        do_req(1'b0, 1'b1, 8'h00, 1'b0, lat, oe_n, wrn_n, rdn_n, rd, ok);
        chk("stat_lat", 32'(lat), 32'd1);
        chk("stat_tx",  rd, 32'h1);
        uart_dataready = 1'b1;
        repeat (2) cyc();
        do_req(1'b0, 1'b1, 8'h00, 1'b0, lat, oe_n, wrn_n, rdn_n, rd, ok);
        chk("stat_txrx", rd, 32'h3);

        // Data write with TX ready
        do_req(1'b1, 1'b0, 8'h41, 1'b0, lat, oe_n, wrn_n, rdn_n, rd, ok);
        chk("wr_lat",     32'(lat),   32'd5);
        chk("wr_oe_cyc",  32'(oe_n),  32'd4);
        chk("wr_wrn_cyc", 32'(wrn_n), 32'd2);
        chk("wr_rdn_cyc", 32'(rdn_n), 32'd0);
        chk("wr_data_o",  {31'h0, ok}, 32'h1);

        // Data read, with select/we toggled while the strobe is low
        bus_data_i = 8'h5A;
        do_req(1'b0, 1'b0, 8'h00, 1'b1, lat, oe_n, wrn_n, rdn_n, rd, ok);
        chk("rd_lat",     32'(lat),   32'd4);
        chk("rd_rdn_cyc", 32'(rdn_n), 32'd2);
        chk("rd_oe_cyc",  32'(oe_n),  32'd0);
        chk("rd_data",    rd,         32'h0000005A);

        // Back-to-back reads; then a status write must leave rdata alone
        bus_data_i = 8'hA5;
        do_req(1'b0, 1'b0, 8'h00, 1'b0, lat, oe_n, wrn_n, rdn_n, rd, ok);
        chk("b2b_rd1", rd, 32'h000000A5);
        bus_data_i = 8'h3C;
        do_req(1'b0, 1'b0, 8'h00, 1'b0, lat, oe_n, wrn_n, rdn_n, rd, ok);
        chk("b2b_rd2", rd, 32'h0000003C);
        do_req(1'b1, 1'b1, 8'hFF, 1'b0, lat, oe_n, wrn_n, rdn_n, rd, ok);
        chk("stat_wr_lat",  32'(lat), 32'd1);
        chk("stat_wr_keep", rd,       32'h0000003C);

        // Data write while the transmitter is busy
        uart_tsre = 1'b0;
        repeat (3) cyc();
        cyc();
        req_valid = 1'b1; req_we = 1'b1; req_sel = 1'b0; req_wdata = 8'hC3;
        repeat (5) cyc();
        chk("txw_wrn",  {31'h0, uart_wrn}, 32'h1);
        chk("txw_busy", {31'h0, busy},     32'h1);
        uart_tsre = 1'b1;
        @(posedge clk);            // first edge that samples the new tsre
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (uart_wrn && n < 10);
        chk("txw_strobe_delay", 32'(n), 32'd3);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!resp_valid && n < 20);
        chk("txw_resp", {31'h0, resp_valid}, 32'h1);
        req_valid = 1'b0;

        // Reset in the middle of the write pulse, with req_valid held high
        cyc();
        req_valid = 1'b1; req_we = 1'b1; req_sel = 1'b0; req_wdata = 8'h77;
        n = 0;
        do begin
            cyc();
            n++;
        end while (uart_wrn && n < 10);
        chk("rst_mid_pulse_seen", {31'h0, uart_wrn}, 32'h0);
        rst = 1'b1;
        cyc();
        chk("rstm_wrn",  {31'h0, uart_wrn},    32'h1);
        chk("rstm_oe",   {31'h0, bus_data_oe}, 32'h0);
        chk("rstm_busy", {31'h0, busy},        32'h0);
        chk("rstm_rv",   {31'h0, resp_valid},  32'h0);
        cyc();
        chk("rstm_req_ignored", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rstm_no_resp", {31'h0, resp_valid}, 32'h0);
        end

        // Randomized traffic
        rand_mode = 1'b1;
        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 3)) cyc();
            do_req(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
                   lat, oe_n, wrn_n, rdn_n, rd, ok);
        end
        rand_mode = 1'b0;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpld_uart_ctrl.md
# cpld_uart_ctrl

Bus-side controller for the CPLD serial port, sitting directly downstream of the MMU. It turns single MMU word requests for the UART data and status registers into correctly timed `uart_rdn`/`uart_wrn` strobes on the shared low byte of the BaseRAM data bus. It returns read data or a write completion through a one-cycle response pulse. The MMU does the address decode (data vs. status), keeps `base_ram_ce_n` high during UART access, and muxes `bus_data_o`/`bus_data_oe` onto `base_ram_data[7:0]`.

## Interface
- `PULSE_CYCLES`, default 2: strobe low width in `clk` cycles; minimum 1.
- `clk` input 1: the single clock for the block; all logic samples on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input 1: request present. Held stable until `resp_valid`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_sel` input 1: 0 = data register, 1 = status register.
- `req_wdata` input 8: write byte.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: read result. Zero-extended byte, or status word.
- `busy` output 1: high whenever state ≠ IDLE.
- `bus_data_i` input 8: `base_ram_data[7:0]` as sampled.
- `bus_data_o` output 8: byte to drive onto the bus.
- `bus_data_oe` output 1: MMU drives `base_ram_data[7:0]` from `bus_data_o` when high.
- `uart_rdn` output 1: CPLD read strobe, active-low.
- `uart_wrn` output 1: CPLD write strobe, active-low.
- `uart_dataready` input 1: asynchronous.
- `uart_tbre` input 1: asynchronous.
- `uart_tsre` input 1: asynchronous.

## Operation
- **Synchronizers.** `uart_dataready`, `uart_tbre` and `uart_tsre` each pass through a 2-flop synchronizer.
  - `rx_ready` = synced dataready.
  - `tx_ready` = synced tbre AND synced tsre.
- **Status word.** `{30'b0, rx_ready, tx_ready}`: bit0 = TX ready, bit1 = RX data ready.
- **States:** IDLE, TX_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE, RD_RECOVER, DONE.
- **IDLE**, when `req_valid` is high:
  - sel=1, read: latch the status word into `resp_rdata`, go to DONE.
  - sel=1, write: ignored; `resp_rdata` keeps its value; go to DONE.
  - sel=0, write: latch `req_wdata`. Go to WR_SETUP if `tx_ready`, otherwise TX_WAIT.
  - sel=0, read: go to RD_PULSE and load the pulse counter with `PULSE_CYCLES-1`.
- **TX_WAIT:** stay until `tx_ready`, then go to WR_SETUP. No timeout.
- **WR_SETUP:** `bus_data_oe=1`, `uart_wrn=1`, for 1 cycle.
- **WR_PULSE:** `bus_data_oe=1`, `uart_wrn=0`, for `PULSE_CYCLES` cycles.
- **WR_HOLD:** `uart_wrn=1`, `bus_data_oe` still 1, for 1 cycle. Then go to DONE.
- **RD_PULSE:** `uart_rdn=0`, `bus_data_oe=0`, for `PULSE_CYCLES` cycles. On the last cycle, `resp_rdata <= {24'b0, bus_data_i}`.
- **RD_RECOVER:** `uart_rdn=1`, for 1 cycle. Then go to DONE.
- **DONE:** `resp_valid=1` for exactly 1 cycle, then go to IDLE.
- `req_valid` is sampled only in IDLE; changes in other states are ignored. A read of data with `rx_ready=0` is still performed; software polls status first.
- `uart_rdn` and `uart_wrn` are never low in the same cycle. `bus_data_oe` is never high while `uart_rdn=0`.

## Timing
- **Reset values:** state IDLE, `uart_rdn=1`, `uart_wrn=1`, `bus_data_oe=0`, `bus_data_o=0`, `resp_valid=0`, `resp_rdata=0`, `busy=0`, synchronizer flops 0.
- All outputs are registered.
- **Latency, measured from the accepting edge to `resp_valid` high** (P = `PULSE_CYCLES`):
  - status read/write: 1 cycle.
  - data read: P+2 cycles.
  - data write with `tx_ready`: P+3 cycles.
  - data write otherwise: P+3 plus the cycles spent in TX_WAIT.
- **Synchronizer delay:** a UART input change is reflected in the status word 2 cycles later.
- **Back-to-back requests:** the requester drops `req_valid` on the edge where it sees `resp_valid`. The earliest next acceptance is 1 cycle after DONE.
- **Reset mid-operation:** on the next edge, strobes go high, `bus_data_oe=0`, state IDLE, and no `resp_valid` is issued for the aborted request.
- **`req_valid` with `rst` high:** ignored.

## Structure
- **Package `uart_pkg`:**
  - state enum;
  - `SEL_DATA=0`, `SEL_STATUS=1`;
  - `STAT_TX_BIT=0`, `STAT_RX_BIT=1`.
- **Sub-module `uart_sync2`:** 1-bit 2-flop synchronizer with `clk`/`rst`, instantiated 3 times.
- The FSM, pulse counter and data registers stay in `cpld_uart_ctrl`.

## Test plan
- **Reset:** assert `rst` during WR_PULSE with P=2. → Next cycle `uart_wrn=1`, `bus_data_oe=0`, `busy=0`, no `resp_valid`.
- **Status read:** tbre=1, tsre=1, dataready=0 held ≥2 cycles, read sel=1. → `resp_valid` 1 cycle later, `resp_rdata=32'h1`. Set dataready=1, wait 2 cycles, read again. → `32'h3`.
- **Data write, TX ready:** write 8'h41 with tx ready, P=2.
  - `bus_data_oe` high for 4 cycles.
  - `uart_wrn` low for exactly 2 cycles, with `bus_data_o=8'h41` throughout.
  - `resp_valid` at +5.
- **Data write, TX busy:** tsre=0 at request. → Block waits in TX_WAIT with `uart_wrn` high. Raise tsre. → Strobe starts 3 cycles later (2 sync + SETUP).
- **Data read:** `bus_data_i=8'h5A`, P=3. → `uart_rdn` low 3 cycles, `resp_rdata=32'h0000005A`, `resp_valid` at +5, `bus_data_oe` stays 0.
- **Protocol rules:** toggle `req_sel`/`req_we` during RD_PULSE → no effect. Issue back-to-back reads → no overlap, `uart_rdn` high ≥1 cycle between pulses.
